// File: rtl/y_signature_collector.sv
// y_signature_collector
//   Compacts a programmed number of samples from the 47-bit y bus into a
//   single MISR signature so two DUT builds can be compared by one word.
//   Command side: start/num_samples in, busy/done out.
//   Sample side : y_valid/y_ready handshake.
//   Optional feature macro: YSIG_GOLDEN_CMP_EN adds golden_sig/mismatch,
//   a compare of the final signature against an expected value.
module y_signature_collector #(
  parameter int unsigned      DATA_W = 47,
  parameter int unsigned      SIG_W  = 48,
  parameter logic [SIG_W-1:0] POLY   = 48'h0000_0000_002D,
  parameter logic [SIG_W-1:0] SEED   = 48'h0000_0000_0000,
  parameter int unsigned      CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic              y_valid,
  output logic              y_ready,
  input  logic [DATA_W-1:0] y,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  sig,
  output logic [CNT_W-1:0]  sample_cnt
`ifdef YSIG_GOLDEN_CMP_EN
  ,
  input  logic [SIG_W-1:0]  golden_sig,
  output logic              mismatch
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One MISR step: shift left, fold the outgoing MSB back through POLY,
  // then XOR in the zero-extended sample.
  function automatic logic [SIG_W-1:0] misr_step(
    input logic [SIG_W-1:0]  cur,
    input logic [DATA_W-1:0] din
  );
    logic [SIG_W-1:0] shifted;
    logic [SIG_W-1:0] feedback;
    logic [SIG_W-1:0] din_ext;
    shifted = {cur[SIG_W-2:0], 1'b0};
    if (cur[SIG_W-1]) begin
      feedback = POLY;
    end else begin
      feedback = {SIG_W{1'b0}};
    end
    din_ext              = {SIG_W{1'b0}};
    din_ext[DATA_W-1:0]  = din;
    return shifted ^ feedback ^ din_ext;
  endfunction

  state_e             state_q,  state_d;
  logic [SIG_W-1:0]   sig_q,    sig_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;

  logic               accept_s;
  logic               last_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               start_acc_s;
  logic               finish_s;

  // Sample handshake decode: a sample is taken only while running.
  always_comb begin
    accept_s  = 1'b0;
    cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    last_s    = 1'b0;
    if (state_q == ST_RUN) begin
      accept_s = y_valid;
      last_s   = (cnt_inc_s == target_q);
    end else begin
      accept_s = 1'b0;
      last_s   = 1'b0;
    end
  end

  // Next-state and registered-output computation for the run controller.
  always_comb begin
    state_d     = state_q;
    sig_d       = sig_q;
    cnt_d       = cnt_q;
    target_d    = target_q;
    busy_d      = busy_q;
    done_d      = done_q;
    start_acc_s = 1'b0;
    finish_s    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_acc_s = 1'b1;
          sig_d       = SEED;
          cnt_d       = {CNT_W{1'b0}};
          target_d    = num_samples;
          done_d      = 1'b0;
          if (num_samples == {CNT_W{1'b0}}) begin
            // Empty run: signature is just the seed.
            state_d  = ST_DONE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            finish_s = 1'b1;
          end else begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        // start is deliberately ignored here, including on the final accept.
        if (accept_s) begin
          sig_d = misr_step(sig_q, y);
          if (cnt_q != target_q) begin
            cnt_d = cnt_inc_s;
          end else begin
            cnt_d = cnt_q;
          end
          if (last_s) begin
            state_d  = ST_DONE;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            finish_s = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sig_d   = SEED;
        cnt_d   = {CNT_W{1'b0}};
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // Run controller registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sig_q    <= SEED;
      cnt_q    <= {CNT_W{1'b0}};
      target_q <= {CNT_W{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign y_ready    = (state_q == ST_RUN);
  assign busy       = busy_q;
  assign done       = done_q;
  assign sig        = sig_q;
  assign sample_cnt = cnt_q;

`ifdef YSIG_GOLDEN_CMP_EN
  logic mismatch_q, mismatch_d;

  // Golden compare: evaluated against the final signature on entry to DONE.
  always_comb begin
    mismatch_d = mismatch_q;
    if (finish_s) begin
      mismatch_d = (sig_d != golden_sig);
    end else if (start_acc_s) begin
      mismatch_d = 1'b0;
    end else begin
      mismatch_d = mismatch_q;
    end
  end

  // Golden compare result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_y_signature_collector.sv
// Bench for y_signature_collector: directed scenarios with literal pins plus
// randomized traffic, all checked every cycle against a run-level model that
// keeps the list of accepted samples and folds it into a signature.
module tb_y_signature_collector;

  localparam logic [47:0] SEED = 48'h0000_0000_0000;
  localparam logic [47:0] POLY = 48'h0000_0000_002D;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] num_samples;
  logic        y_valid;
  logic        y_ready;
  logic [46:0] y;
  logic        busy;
  logic        done;
  logic [47:0] sig;
  logic [15:0] sample_cnt;
`ifdef YSIG_GOLDEN_CMP_EN
  logic [47:0] golden_sig;
  logic        mismatch;
  logic        m_mm;
`endif

  y_signature_collector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_samples(num_samples),
    .y_valid    (y_valid),
    .y_ready    (y_ready),
    .y          (y),
    .busy       (busy),
    .done       (done),
    .sig        (sig),
    .sample_cnt (sample_cnt)
`ifdef YSIG_GOLDEN_CMP_EN
    ,
    .golden_sig (golden_sig),
    .mismatch   (mismatch)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Run-level model
  typedef enum int {P_IDLE, P_RUN, P_DONE} phase_e;
  phase_e      m_phase = P_IDLE;
  logic [46:0] m_samples[$];
  int          m_target = 0;

  function automatic logic [47:0] fold();
    logic [47:0] s;
    logic        msb;
    s = SEED;
    foreach (m_samples[i]) begin
      msb = s[47];
      s   = s << 1;
      if (msb) s = s ^ POLY;
      s = s ^ {1'b0, m_samples[i]};
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m_phase = P_IDLE;
      m_samples.delete();
      m_target = 0;
`ifdef YSIG_GOLDEN_CMP_EN
      m_mm = 1'b0;
`endif
    end else if (m_phase == P_RUN) begin
      if (y_valid) begin
        m_samples.push_back(y);
        if (m_samples.size() == m_target) begin
          m_phase = P_DONE;
`ifdef YSIG_GOLDEN_CMP_EN
          m_mm = (fold() != golden_sig);
`endif
        end
      end
    end else begin
      if (start) begin
        m_samples.delete();
        m_target = int'(num_samples);
`ifdef YSIG_GOLDEN_CMP_EN
        m_mm = 1'b0;
`endif
        if (num_samples == 16'd0) begin
          m_phase = P_DONE;
`ifdef YSIG_GOLDEN_CMP_EN
          m_mm = (SEED != golden_sig);
`endif
        end else begin
          m_phase = P_RUN;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("y_ready",    64'(y_ready),    64'(m_phase == P_RUN));
    chk("busy",       64'(busy),       64'(m_phase == P_RUN));
    chk("done",       64'(done),       64'(m_phase == P_DONE));
    chk("sig",        64'(sig),        64'(fold()));
    chk("sample_cnt", 64'(sample_cnt), 64'(m_samples.size()));
`ifdef YSIG_GOLDEN_CMP_EN
    chk("mismatch",   64'(mismatch),   64'(m_mm));
`endif
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic do_start(input logic [15:0] n);
    num_samples = n;
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  task automatic feed(input logic [46:0] v);
    y       = v;
    y_valid = 1'b1;
    step();
    y_valid = 1'b0;
  endtask

  function automatic logic [46:0] rand47();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[46:0];
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; num_samples = 16'd0; y_valid = 1'b0; y = 47'd0;
`ifdef YSIG_GOLDEN_CMP_EN
    golden_sig = 48'd0; m_mm = 1'b0;
`endif
    step(); step();
    chk("rst_sig",  64'(sig),  64'(SEED));
    chk("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    step();

    // Single sample run
    do_start(16'd1);
    chk("t1_start_busy", 64'(busy), 64'd1);
    feed(47'h1);
    chk("t1_sig",  64'(sig),        64'h1);
    chk("t1_cnt",  64'(sample_cnt), 64'd1);
    chk("t1_done", 64'(done),       64'd1);
    chk("t1_rdy",  64'(y_ready),    64'd0);

    // Two samples, then re-seeded runs
`ifdef YSIG_GOLDEN_CMP_EN
    golden_sig = 48'h2;
`endif
    do_start(16'd2);
    chk("t2_seed", 64'(sig), 64'(SEED));
    feed(47'h1);
    feed(47'h0);
    chk("t2_sig", 64'(sig), 64'h2);
`ifdef YSIG_GOLDEN_CMP_EN
    chk("t6_match", 64'(mismatch), 64'd0);
    golden_sig = 48'h3;
    do_start(16'd2);
    feed(47'h1);
    feed(47'h0);
    chk("t6_mismatch", 64'(mismatch), 64'd1);
`endif
    for (int r = 0; r < 3; r++) begin
      do_start(16'd3);
      chk("t2_reseed", 64'(sig), 64'(SEED));
      for (int k = 0; k < 3; k++) feed(rand47());
      chk("t2_done", 64'(done), 64'd1);
    end

    // Feedback path
    do_start(16'd3);
    feed(47'h4000_0000_0000);
    feed(47'h0);
    chk("t3_msb", 64'(sig), 64'h8000_0000_0000);
    feed(47'h0);
    chk("t3_fb",  64'(sig), 64'h2D);

    // Empty run
    do_start(16'd0);
    chk("t4_done", 64'(done),    64'd1);
    chk("t4_sig",  64'(sig),     64'(SEED));
    chk("t4_rdy",  64'(y_ready), 64'd0);
    y_valid = 1'b1; y = 47'h55; step(); y_valid = 1'b0;
    chk("t4_hold", 64'(sample_cnt), 64'd0);

    // Toggling valid with a start pulsed mid-run
    do_start(16'd4);
    for (int i = 0; i < 8; i++) begin
      y_valid     = (i % 2 == 0);
      y           = rand47();
      start       = (i == 3);
      num_samples = 16'd7;
      step();
    end
    start = 1'b0; y_valid = 1'b0;
    chk("t5_cnt",  64'(sample_cnt), 64'd4);
    chk("t5_done", 64'(done),       64'd1);

    // Start on the same cycle as the final accept
    do_start(16'd1);
    y = 47'h5; y_valid = 1'b1; start = 1'b1; num_samples = 16'd3;
    step();
    start = 1'b0; y_valid = 1'b0;
    chk("t5_last_cnt", 64'(sample_cnt), 64'd1);
    chk("t5_last_sig", 64'(sig),        64'h5);
    step();
    chk("t5_last_busy", 64'(busy), 64'd0);

    // Reset mid-run
    do_start(16'd5);
    feed(rand47());
    feed(rand47());
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t5_rst_busy", 64'(busy),       64'd0);
    chk("t5_rst_done", 64'(done),       64'd0);
    chk("t5_rst_sig",  64'(sig),        64'(SEED));
    chk("t5_rst_cnt",  64'(sample_cnt), 64'd0);
    step();

    // Maximum target does not finish early
    do_start(16'hFFFF);
    y_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      y = rand47();
      step();
    end
    y_valid = 1'b0;
    chk("max_cnt",  64'(sample_cnt), 64'd20);
    chk("max_busy", 64'(busy),       64'd1);
    rst_n = 1'b0; step(); rst_n = 1'b1; step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      start       = ($urandom_range(0, 5) == 0);
      num_samples = 16'($urandom_range(0, 6));
      y_valid     = ($urandom_range(0, 1) == 1);
      y           = rand47();
`ifdef YSIG_GOLDEN_CMP_EN
      golden_sig  = ($urandom_range(0, 1) == 1) ? 48'd0 : {rand47(), 1'b1};
`endif
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
